// File: rtl/bicubic_weight_gen.sv
// Four-tap bicubic/bilinear weight generator: one fractional position in, weights w0..w3 out.
// Four-stage pipeline with a single global advance enable and a sideband tag.
`timescale 1ns/1ps
module bicubic_weight_gen #(
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 4,
    parameter int NORM   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FRAC_W-1:0]   x_frac,
    input  logic [FRAC_W:0]     bi_a,
    input  logic                mode,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FRAC_W+2:0]   bi_w0,
    output logic [FRAC_W+2:0]   bi_w1,
    output logic [FRAC_W+2:0]   bi_w2,
    output logic [FRAC_W+2:0]   bi_w3,
    output logic [TAG_W-1:0]    out_tag
);

    localparam int DW = FRAC_W + 2;
    localparam int SW = 2 * DW;
    localparam int CW = 3 * DW;
    localparam int XW = 4 * FRAC_W + 10;
    localparam int WW = FRAC_W + 3;

    localparam logic [DW-1:0]        ONE_D   = DW'(1) << FRAC_W;
    localparam logic [DW-1:0]        TWO_D   = DW'(2) << FRAC_W;
    localparam logic signed [XW-1:0] ONE_F   = XW'(1) << FRAC_W;
    localparam logic signed [XW-1:0] COEF_A  = XW'(2) << FRAC_W;
    localparam logic signed [XW-1:0] COEF_B  = XW'(3) << FRAC_W;
    localparam logic signed [XW-1:0] ONE_4F  = XW'(1) << (4 * FRAC_W);
    localparam logic signed [XW-1:0] FOUR_3F = XW'(4) << (3 * FRAC_W);
    localparam logic signed [XW-1:0] HALF_3F = XW'(1) << (3 * FRAC_W - 1);
    localparam logic signed [XW-1:0] SAT_HI  = (XW'(1) << (FRAC_W + 2)) - XW'(1);
    localparam logic signed [XW-1:0] SAT_LO  = -(XW'(1) << (FRAC_W + 2));

    function automatic logic [WW-1:0] satW(input logic signed [XW-1:0] v);
        if (v > SAT_HI) return SAT_HI[WW-1:0];
        if (v < SAT_LO) return SAT_LO[WW-1:0];
        return v[WW-1:0];
    endfunction

    function automatic logic signed [XW-1:0] sx(input logic [WW-1:0] w);
        return XW'($signed(w));
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage registers
    logic                s1Valid, s1Mode;
    logic [FRAC_W-1:0]   s1T;
    logic [FRAC_W:0]     s1A;
    logic [TAG_W-1:0]    s1Tag;
    logic [DW-1:0]       s1D [4];

    logic                s2Valid, s2Mode;
    logic [FRAC_W-1:0]   s2T;
    logic [FRAC_W:0]     s2A;
    logic [TAG_W-1:0]    s2Tag;
    logic [DW-1:0]       s2D [4];
    logic [SW-1:0]       s2Sq [4];

    logic                s3Valid, s3Mode;
    logic [FRAC_W-1:0]   s3T;
    logic [FRAC_W:0]     s3A;
    logic [TAG_W-1:0]    s3Tag;
    logic [CW-1:0]       s3Cube [4];
    logic signed [XW-1:0] s3NearB [4];
    logic signed [XW-1:0] s3FarQ [4];
    logic                s3Near [4];
    logic                s3Two [4];

    // Combinational nets between stages
    logic [DW-1:0]        dIn [4];
    logic signed [XW-1:0] s2AX;
    logic signed [XW-1:0] sqX [4];
    logic signed [XW-1:0] dX [4];
    logic [CW-1:0]        cubeN [4];
    logic signed [XW-1:0] nearBN [4];
    logic signed [XW-1:0] farQN [4];
    logic                 nearN [4];
    logic                 twoN [4];

    logic signed [XW-1:0] aX, cAX, normX;
    logic signed [XW-1:0] cubeX [4];
    logic signed [XW-1:0] nearX [4];
    logic signed [XW-1:0] farX [4];
    logic signed [XW-1:0] rawX [4];
    logic signed [XW-1:0] rndX [4];
    logic [WW-1:0]        tapW [4];
    logic [WW-1:0]        wN [4];

    always_comb begin
        dIn[0] = ONE_D + DW'(x_frac);
        dIn[1] = DW'(x_frac);
        dIn[2] = ONE_D - DW'(x_frac);
        dIn[3] = TWO_D - DW'(x_frac);
    end

    // Everything is scaled by 2^(4*FRAC_W) so no bits are dropped before the final rounding.
    always_comb begin
        s2AX = XW'(s2A);
        for (int unsigned i = 0; i < 4; i++) begin
            sqX[i]    = XW'(s2Sq[i]);
            dX[i]     = XW'(s2D[i]);
            cubeN[i]  = CW'(s2D[i]) * CW'(s2Sq[i]);
            nearBN[i] = (COEF_B - s2AX) * sqX[i];
            farQN[i]  = (dX[i] <<< (2 * FRAC_W + 3)) - ((sqX[i] * XW'(5)) <<< FRAC_W) - FOUR_3F;
            nearN[i]  = s2D[i] <= ONE_D;
            twoN[i]   = s2D[i] == TWO_D;
        end
    end

    always_comb begin
        aX  = XW'(s3A);
        cAX = COEF_A - aX;
        for (int unsigned i = 0; i < 4; i++) begin
            cubeX[i] = XW'(s3Cube[i]);
            nearX[i] = cAX * cubeX[i] - (s3NearB[i] <<< FRAC_W) + ONE_4F;
            farX[i]  = -(aX * (cubeX[i] + s3FarQ[i]));
            if (s3Two[i])
                rawX[i] = '0;
            else if (s3Near[i])
                rawX[i] = nearX[i];
            else
                rawX[i] = farX[i];
            rndX[i] = (rawX[i] + HALF_3F) >>> (3 * FRAC_W);
            tapW[i] = satW(rndX[i]);
        end
        normX = ONE_F - sx(tapW[0]) - sx(tapW[2]) - sx(tapW[3]);
        if (s3Mode) begin
            wN[0] = '0;
            wN[1] = satW(ONE_F - XW'(s3T));
            wN[2] = WW'(s3T);
            wN[3] = '0;
        end else begin
            wN[0] = tapW[0];
            wN[1] = (NORM != 0) ? satW(normX) : tapW[1];
            wN[2] = tapW[2];
            wN[3] = tapW[3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0; s1Mode <= 1'b0; s1T <= '0; s1A <= '0; s1Tag <= '0;
            s2Valid <= 1'b0; s2Mode <= 1'b0; s2T <= '0; s2A <= '0; s2Tag <= '0;
            s3Valid <= 1'b0; s3Mode <= 1'b0; s3T <= '0; s3A <= '0; s3Tag <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                s1D[i]     <= '0;
                s2D[i]     <= '0;
                s2Sq[i]    <= '0;
                s3Cube[i]  <= '0;
                s3NearB[i] <= '0;
                s3FarQ[i]  <= '0;
                s3Near[i]  <= 1'b0;
                s3Two[i]   <= 1'b0;
            end
            out_valid <= 1'b0;
            out_tag   <= '0;
            bi_w0     <= '0;
            bi_w1     <= '0;
            bi_w2     <= '0;
            bi_w3     <= '0;
        end else if (en) begin
            s1Valid <= in_valid; s1Mode <= mode; s1T <= x_frac; s1A <= bi_a; s1Tag <= in_tag;
            s2Valid <= s1Valid;  s2Mode <= s1Mode; s2T <= s1T; s2A <= s1A; s2Tag <= s1Tag;
            s3Valid <= s2Valid;  s3Mode <= s2Mode; s3T <= s2T; s3A <= s2A; s3Tag <= s2Tag;
            for (int unsigned i = 0; i < 4; i++) begin
                s1D[i]     <= dIn[i];
                s2D[i]     <= s1D[i];
                s2Sq[i]    <= SW'(s1D[i]) * SW'(s1D[i]);
                s3Cube[i]  <= cubeN[i];
                s3NearB[i] <= nearBN[i];
                s3FarQ[i]  <= farQN[i];
                s3Near[i]  <= nearN[i];
                s3Two[i]   <= twoN[i];
            end
            out_valid <= s3Valid;
            out_tag   <= s3Tag;
            bi_w0     <= wN[0];
            bi_w1     <= wN[1];
            bi_w2     <= wN[2];
            bi_w3     <= wN[3];
        end
    end

endmodule

// File: tb/tb_bicubic_weight_gen.sv
// Directed and swept checks of bicubic_weight_gen against a real-valued kernel model.
`timescale 1ns/1ps
module tb_bicubic_weight_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x_frac;
    logic [8:0]  bi_a;
    logic        mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] bi_w0, bi_w1, bi_w2, bi_w3;
    logic [3:0]  out_tag;

    bicubic_weight_gen #(.FRAC_W(8), .TAG_W(4), .NORM(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_frac(x_frac), .bi_a(bi_a), .mode(mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .bi_w0(bi_w0), .bi_w1(bi_w1), .bi_w2(bi_w2), .bi_w3(bi_w3),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [43:0] w;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        prevStall = 1'b0;
    logic [48:0] prevOut = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [43:0] pack4(input int a, input int b, input int c, input int d);
        return {11'(a), 11'(b), 11'(c), 11'(d)};
    endfunction

    function automatic int sumOf(input logic [43:0] w);
        logic [10:0] p0, p1, p2, p3;
        p0 = w[43:33]; p1 = w[32:22]; p2 = w[21:11]; p3 = w[10:0];
        return int'($signed(p0)) + int'($signed(p1)) + int'($signed(p2)) + int'($signed(p3));
    endfunction

    // Kernel value at distance D/256 with a = -A/256; all terms are exact dyadic reals.
    function automatic int kern(input int D, input int A);
        real d, a, w, r;
        int  ri;
        d = D / 256.0;
        a = -A / 256.0;
        if (D <= 256)
            w = (a + 2.0) * d * d * d - (a + 3.0) * d * d + 1.0;
        else if (D < 512)
            w = a * (d * d * d - 5.0 * d * d + 8.0 * d - 4.0);
        else
            w = 0.0;
        r  = $floor(w * 256.0 + 0.5);
        ri = int'(r);
        if (ri > 1023)  ri = 1023;
        if (ri < -1024) ri = -1024;
        return ri;
    endfunction

    function automatic logic [43:0] model(input int t, input int A, input logic md);
        int w0, w1, w2, w3;
        if (md) begin
            w0 = 0; w1 = 256 - t; w2 = t; w3 = 0;
        end else begin
            w0 = kern(256 + t, A);
            w2 = kern(256 - t, A);
            w3 = kern(512 - t, A);
            w1 = 256 - w0 - w2 - w3;
            if (w1 > 1023)  w1 = 1023;
            if (w1 < -1024) w1 = -1024;
        end
        return pack4(w0, w1, w2, w3);
    endfunction

    // One clock with handshake bookkeeping sampled on the falling edge.
    task automatic tick();
        logic [43:0] got;
        exp_t        e;
        @(negedge clk);
        got = {bi_w0, bi_w1, bi_w2, bi_w3};
        chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
        if (prevStall)
            chk("stall_hold", {out_valid, out_tag, got}, prevOut);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("weights", got, e.w);
                chk("tag", out_tag, e.tag);
                chk("sum", sumOf(got), 256);
            end
        end
        if (in_valid && in_ready) begin
            e.w   = model(int'(x_frac), int'(bi_a), mode);
            e.tag = in_tag;
            sb.push_back(e);
        end
        prevStall = out_valid && !out_ready;
        prevOut   = {out_valid, out_tag, got};
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxCycles);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < maxCycles && sb.size() > 0; k++)
            tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic runOne(input int t, input int A, input logic md, input logic [3:0] tg,
                          output logic [43:0] w, output logic [3:0] otag);
        x_frac = 8'(t); bi_a = 9'(A); mode = md; in_tag = tg;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("ready_before_accept", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_frac = ~x_frac; bi_a = ~bi_a; mode = ~md; in_tag = ~tg;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            chk("latency", out_valid, (k == 3));
        end
        w    = {bi_w0, bi_w1, bi_w2, bi_w3};
        otag = out_tag;
        @(posedge clk);
        #1;
        chk("valid_drop", out_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no finish in time (checks %0d, errors %0d)", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [43:0] w;
        logic [3:0]  tg;
        int          n;
        int          aList[5];

        aList = '{0, 128, 192, 256, 511};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x_frac = '0; bi_a = '0; mode = 1'b0; in_tag = '0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_weights", {bi_w0, bi_w1, bi_w2, bi_w3}, 44'd0);
        chk("rst_tag", out_tag, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", in_ready, 1'b1);

        runOne(0, 128, 1'b0, 4'h5, w, tg);
        chk("t0_a128", w, pack4(0, 256, 0, 0));
        chk("t0_tag", tg, 4'h5);
        runOne(128, 128, 1'b0, 4'hA, w, tg);
        chk("t128_a128", w, pack4(-16, 144, 144, -16));
        chk("t128_sum", sumOf(w), 256);
        chk("t128_tag", tg, 4'hA);
        runOne(64, 511, 1'b1, 4'h3, w, tg);
        chk("bilin_a511", w, pack4(0, 192, 64, 0));
        runOne(64, 0, 1'b1, 4'hC, w, tg);
        chk("bilin_a0", w, pack4(0, 192, 64, 0));
        chk("bilin_tag", tg, 4'hC);
        runOne(128, 0, 1'b0, 4'h7, w, tg);
        chk("t128_a0", w, pack4(0, 128, 128, 0));
        runOne(255, 300, 1'b1, 4'h1, w, tg);
        chk("bilin_t255", w, pack4(0, 1, 255, 0));

        out_ready = 1'b1;
        n = 0;
        foreach (aList[j]) begin
            for (int t = 0; t < 256; t++) begin
                x_frac = 8'(t); bi_a = 9'(aList[j]); mode = 1'b0;
                in_tag = 4'(n); in_valid = 1'b1;
                tick();
                if (n >= 3) chk("throughput", out_valid, 1'b1);
                n++;
            end
        end
        drain(20);

        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            x_frac    = 8'($urandom);
            bi_a      = 9'($urandom);
            mode      = ($urandom_range(0, 3) == 0);
            in_tag    = 4'($urandom);
            tick();
        end
        drain(40);

        out_ready = 1'b1; x_frac = 8'd128; bi_a = 9'd128; mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_tag = 4'(k); in_valid = 1'b1;
            tick();
        end
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_w0", bi_w0, 11'h7F0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_weights", {bi_w0, bi_w1, bi_w2, bi_w3}, 44'd0);
        chk("async_rst_tag", out_tag, 4'd0);
        sb.delete();
        prevStall = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("no_stale_valid", out_valid, 1'b0);
        end
        runOne(128, 0, 1'b0, 4'h9, w, tg);
        chk("post_rst_w", w, pack4(0, 128, 128, 0));
        chk("post_rst_tag", tg, 4'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
